// File: rtl/img_proc_pkg.sv
// Shared types and constants for the 3x3 edge engine.
//   edge_mode_t : runtime filter selection, latched on start-of-frame
//   acc_width() : signed accumulator width for a given pixel width
//   addr_width(): line-buffer address width for a given line length
package img_proc_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    SOBEL_H = 2'd1,
    SOBEL_V = 2'd2,
    MAG     = 2'd3
  } edge_mode_t;

  // Four guard bits: the Sobel weights sum to 4 per side, plus a sign bit, and
  // |Gh|+|Gv| still fits once the result is widened by one more bit.
  localparam int unsigned AccGuardW = 4;

  // Sobel kernel weights: outer taps and centre tap of the non-zero rows/columns.
  localparam int SobelSide = 1;
  localparam int SobelMid  = 2;

  function automatic int unsigned acc_width(int unsigned data_w);
    return data_w + AccGuardW;
  endfunction

  function automatic int unsigned addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv3x3_edge_engine_if.sv
// Pixel stream bundle for the 3x3 edge engine.
//   iSOF/iDVAL/iDATA          : input raster stream
//   iMode/iThreshEn/iThresh   : frame controls, only looked at on iSOF
//   oDATA/oDVAL/oBorder       : filtered output stream
// master drives the input stream, slave is the engine.
interface conv3x3_edge_engine_if #(
  parameter int unsigned DATA_W = 12
);

  logic              iSOF;
  logic              iDVAL;
  logic [DATA_W-1:0] iDATA;
  logic [1:0]        iMode;
  logic              iThreshEn;
  logic [DATA_W-1:0] iThresh;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic              oBorder;

  modport master (
    output iSOF, iDVAL, iDATA, iMode, iThreshEn, iThresh,
    input  oDATA, oDVAL, oBorder
  );

  modport slave (
    input  iSOF, iDVAL, iDATA, iMode, iThreshEn, iThresh,
    output oDATA, oDVAL, oBorder
  );

endinterface

// File: rtl/line_buffer.sv
// One line of pixel storage, read-before-write at a single address.
//   clk_i   : pixel clock
//   we_i    : write enable (one per accepted pixel)
//   addr_i  : column address
//   wdata_i : pixel written at addr_i on the clock edge
//   rdata_o : pixel previously stored at addr_i (combinational read)
// Contents are never cleared; consumers mask stale data themselves.
module line_buffer
  import img_proc_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned AddrW     = addr_width(IMG_WIDTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [IMG_WIDTH];

  // Async read returns the old word in the same cycle the new one is written.
  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv3x3_edge_engine.sv
// Streaming 3x3 convolution engine: pass-through, horizontal/vertical Sobel or
// |Gh|+|Gv|, with optional binarising threshold and border masking.
//   iCLK : pixel clock
//   iRST : synchronous active-high reset
//   pix  : pixel stream (slave side), see conv3x3_edge_engine_if
// Two-stage pipeline: stage 1 shifts the window and writes the line buffers,
// stage 2 computes, saturates, thresholds and registers the output.
module conv3x3_edge_engine
  import img_proc_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned X_W       = 11
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  conv3x3_edge_engine_if.slave  pix
);

  localparam int unsigned      AccW    = acc_width(DATA_W);
  localparam int unsigned      LbAddrW = addr_width(IMG_WIDTH);
  localparam logic [DATA_W-1:0] PixMax = '1;
  localparam logic [X_W-1:0]   XLast   = X_W'(IMG_WIDTH - 1);

  function automatic logic signed [AccW-1:0] sx(logic [DATA_W-1:0] v);
    return signed'(AccW'(v));
  endfunction

  // Raster position
  logic [X_W-1:0] x_q, x_d, y_q, y_d, x_cur, y_cur;

  // Frame controls latched on iSOF
  edge_mode_t        mode_q;
  logic              thresh_en_q;
  logic [DATA_W-1:0] thresh_q;

  // Stage 1
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              dval_s1_q, border_s1_q;

  // Stage 2
  logic signed [AccW-1:0] gh, gv;
  logic [AccW-1:0]        abs_h, abs_v;
  logic [AccW:0]          res_wide;
  logic [DATA_W-1:0]      res_sat, res_out;
  logic [DATA_W-1:0]      odata_q;
  logic                   odval_q, oborder_q;

  // iSOF retargets the current pixel to (0,0).
  always_comb begin
    x_cur = pix.iSOF ? '0 : x_q;
    y_cur = pix.iSOF ? '0 : y_q;
    x_d   = x_cur;
    y_d   = y_cur;
    if (pix.iDVAL) begin
      if (x_cur == XLast) begin
        x_d = '0;
        if (y_cur != '1) begin
          y_d = y_cur + 1'b1;
        end
      end else begin
        x_d = x_cur + 1'b1;
      end
    end
  end

  // Row 1 buffer holds the previous line; its old word cascades into row 0.
  line_buffer #(
    .DATA_W    (DATA_W),
    .IMG_WIDTH (IMG_WIDTH),
    .AddrW     (LbAddrW)
  ) u_lb_row1 (
    .clk_i   (iCLK),
    .we_i    (pix.iDVAL),
    .addr_i  (x_cur[LbAddrW-1:0]),
    .wdata_i (pix.iDATA),
    .rdata_o (lb1_rd)
  );

  line_buffer #(
    .DATA_W    (DATA_W),
    .IMG_WIDTH (IMG_WIDTH),
    .AddrW     (LbAddrW)
  ) u_lb_row0 (
    .clk_i   (iCLK),
    .we_i    (pix.iDVAL),
    .addr_i  (x_cur[LbAddrW-1:0]),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= PASS;
      thresh_en_q <= 1'b0;
      thresh_q    <= '0;
      dval_s1_q   <= 1'b0;
      border_s1_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dval_s1_q <= pix.iDVAL;
      if (pix.iSOF) begin
        mode_q      <= edge_mode_t'(pix.iMode);
        thresh_en_q <= pix.iThreshEn;
        thresh_q    <= pix.iThresh;
      end
      if (pix.iDVAL) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb0_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= pix.iDATA;
        // Window is incomplete until two full columns and rows have arrived.
        border_s1_q <= (x_cur < X_W'(2)) || (y_cur < X_W'(2));
      end
    end
  end

  always_comb begin
    gh = AccW'((SobelSide * sx(win_q[2][0]) + SobelMid * sx(win_q[2][1])
              + SobelSide * sx(win_q[2][2]))
             - (SobelSide * sx(win_q[0][0]) + SobelMid * sx(win_q[0][1])
              + SobelSide * sx(win_q[0][2])));
    gv = AccW'((SobelSide * sx(win_q[0][2]) + SobelMid * sx(win_q[1][2])
              + SobelSide * sx(win_q[2][2]))
             - (SobelSide * sx(win_q[0][0]) + SobelMid * sx(win_q[1][0])
              + SobelSide * sx(win_q[2][0])));
    abs_h = gh[AccW-1] ? unsigned'(-gh) : unsigned'(gh);
    abs_v = gv[AccW-1] ? unsigned'(-gv) : unsigned'(gv);

    res_wide = '0;
    unique case (mode_q)
      PASS:    res_wide = {{(AccW + 1 - DATA_W){1'b0}}, win_q[1][1]};
      SOBEL_H: res_wide = {1'b0, abs_h};
      SOBEL_V: res_wide = {1'b0, abs_v};
      MAG:     res_wide = {1'b0, abs_h} + {1'b0, abs_v};
    endcase

    res_sat = (res_wide > {{(AccW + 1 - DATA_W){1'b0}}, PixMax}) ? PixMax
                                                                : res_wide[DATA_W-1:0];
    res_out = res_sat;
    if (thresh_en_q) begin
      res_out = (res_sat >= thresh_q) ? PixMax : '0;
    end
    // Border masking wins over thresholding.
    if (border_s1_q) begin
      res_out = '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      odata_q   <= '0;
      odval_q   <= 1'b0;
      oborder_q <= 1'b0;
    end else begin
      odval_q <= dval_s1_q;
      if (dval_s1_q) begin
        odata_q   <= res_out;
        oborder_q <= border_s1_q;
      end
    end
  end

  assign pix.oDATA   = odata_q;
  assign pix.oDVAL   = odval_q;
  assign pix.oBorder = oborder_q;

endmodule

// File: tb/tb_conv3x3_edge_engine.sv
// Self-checking bench for conv3x3_edge_engine on an 8x8 frame.
module tb_conv3x3_edge_engine;

  localparam int DW  = 12;
  localparam int IW  = 8;
  localparam int XW  = 4;
  localparam int MAX = 4095;
  localparam int NP  = IW * IW;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  conv3x3_edge_engine_if #(.DATA_W(DW)) pix ();

  conv3x3_edge_engine #(
    .DATA_W    (DW),
    .IMG_WIDTH (IW),
    .X_W       (XW)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .pix  (pix)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int img [IW][IW];
  int in_cyc [NP];
  int saved [NP];
  int cap_data[$];
  int cap_border[$];
  int cap_cyc[$];
  int checks = 0;
  int errors = 0;

  always @(negedge iCLK) begin
    if (pix.oDVAL === 1'b1) begin
      cap_data.push_back(int'(pix.oDATA));
      cap_border.push_back(int'(pix.oBorder));
      cap_cyc.push_back(cyc);
    end
  end

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected output for the input pixel at column x, row y of the current image.
  function automatic int ref_pix(int x, int y, int mode, int ten, int th);
    int gh, gv, r;
    if (x < 2 || y < 2) return 0;
    gh = (img[y][x-2] + 2 * img[y][x-1] + img[y][x])
       - (img[y-2][x-2] + 2 * img[y-2][x-1] + img[y-2][x]);
    gv = (img[y-2][x] + 2 * img[y-1][x] + img[y][x])
       - (img[y-2][x-2] + 2 * img[y-1][x-2] + img[y][x-2]);
    case (mode)
      0:       r = img[y-1][x-1];
      1:       r = iabs(gh);
      2:       r = iabs(gv);
      default: r = iabs(gh) + iabs(gv);
    endcase
    if (r > MAX) r = MAX;
    if (ten != 0) r = (r >= th) ? MAX : 0;
    return r;
  endfunction

  function automatic int exp_border(int i);
    return ((i % IW) < 2 || (i / IW) < 2) ? 1 : 0;
  endfunction

  task automatic fill_flat(input int v);
    for (int y = 0; y < IW; y++) for (int x = 0; x < IW; x++) img[y][x] = v;
  endtask

  task automatic fill_step(input int hi);
    for (int y = 0; y < IW; y++) for (int x = 0; x < IW; x++) img[y][x] = (y < 4) ? 0 : hi;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < IW; y++)
      for (int x = 0; x < IW; x++) img[y][x] = int'($urandom_range(0, MAX));
  endtask

  task automatic scramble_ctrl(input int post_mode);
    if (post_mode < 0) begin
      pix.iMode     = 2'($urandom_range(0, 3));
      pix.iThreshEn = 1'($urandom_range(0, 1));
      pix.iThresh   = 12'($urandom_range(0, MAX));
    end else begin
      pix.iMode     = 2'(post_mode);
      pix.iThreshEn = 1'b0;
      pix.iThresh   = 12'd0;
    end
  endtask

  // Drives npix pixels of img starting with iSOF; controls outside iSOF are
  // either randomised (post_mode < 0) or forced to post_mode.
  task automatic drive_frame(input int mode, input int ten, input int th, input int gap,
                             input int post_mode, input int npix, input int tail);
    cap_data.delete();
    cap_border.delete();
    cap_cyc.delete();
    for (int i = 0; i < npix; i++) begin
      pix.iSOF  = (i == 0);
      pix.iDVAL = 1'b1;
      pix.iDATA = 12'(img[i / IW][i % IW]);
      if (i == 0) begin
        pix.iMode     = 2'(mode);
        pix.iThreshEn = 1'(ten);
        pix.iThresh   = 12'(th);
      end else begin
        scramble_ctrl(post_mode);
      end
      in_cyc[i] = cyc;
      @(posedge iCLK); #1;
      pix.iSOF  = 1'b0;
      pix.iDVAL = 1'b0;
      pix.iDATA = 12'($urandom_range(0, MAX));
      scramble_ctrl(post_mode);
      repeat (gap) begin
        @(posedge iCLK); #1;
      end
    end
    repeat (tail) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    checks++;
    if (pix.oDVAL !== 1'b0) begin
      errors++; $display("FAIL reset_dval got %0b want 0", pix.oDVAL);
    end
    checks++;
    if (pix.oDATA !== 12'd0) begin
      errors++; $display("FAIL reset_data got %0d want 0", pix.oDATA);
    end
    checks++;
    if (pix.oBorder !== 1'b0) begin
      errors++; $display("FAIL reset_border got %0b want 0", pix.oBorder);
    end
    iRST = 1'b0;
    @(posedge iCLK); #1;
  endtask

  task automatic test_flat();
    int e;
    fill_flat(100);
    for (int m = 0; m < 4; m++) begin
      drive_frame(m, 0, 0, 0, -1, NP, 4);
      checks++;
      if (cap_data.size() != NP) begin
        errors++; $display("FAIL flat_count m=%0d got %0d want %0d", m, cap_data.size(), NP);
      end
      for (int i = 0; i < NP && i < cap_data.size(); i++) begin
        e = (exp_border(i) != 0) ? 0 : ((m == 0) ? 100 : 0);
        checks++;
        if (cap_data[i] !== e || cap_border[i] !== exp_border(i) ||
            cap_cyc[i] !== in_cyc[i] + 2) begin
          errors++;
          $display("FAIL flat m=%0d i=%0d got d=%0d b=%0d c=%0d want d=%0d b=%0d c=%0d",
                   m, i, cap_data[i], cap_border[i], cap_cyc[i], e, exp_border(i),
                   in_cyc[i] + 2);
        end
      end
    end
  endtask

  task automatic test_step();
    int e;
    fill_step(500);
    for (int m = 1; m < 4; m++) begin
      drive_frame(m, 0, 0, 0, -1, NP, 4);
      checks++;
      if (cap_data.size() != NP) begin
        errors++; $display("FAIL step_count m=%0d got %0d want %0d", m, cap_data.size(), NP);
      end
      for (int i = 0; i < NP && i < cap_data.size(); i++) begin
        e = ref_pix(i % IW, i / IW, m, 0, 0);
        checks++;
        if (cap_data[i] !== e || cap_border[i] !== exp_border(i) ||
            cap_cyc[i] !== in_cyc[i] + 2) begin
          errors++;
          $display("FAIL step m=%0d i=%0d got d=%0d b=%0d c=%0d want d=%0d b=%0d c=%0d",
                   m, i, cap_data[i], cap_border[i], cap_cyc[i], e, exp_border(i),
                   in_cyc[i] + 2);
        end
      end
      if (cap_data.size() == NP) begin
        // Centre rows 3 and 4 straddle the edge; centre row 5 does not.
        checks++;
        if (cap_data[4 * IW + 3] !== ((m == 2) ? 0 : 2000)) begin
          errors++; $display("FAIL step_row3 m=%0d got %0d", m, cap_data[4 * IW + 3]);
        end
        checks++;
        if (cap_data[5 * IW + 6] !== ((m == 2) ? 0 : 2000)) begin
          errors++; $display("FAIL step_row4 m=%0d got %0d", m, cap_data[5 * IW + 6]);
        end
        checks++;
        if (cap_data[6 * IW + 3] !== 0) begin
          errors++; $display("FAIL step_row5 m=%0d got %0d want 0", m, cap_data[6 * IW + 3]);
        end
      end
    end
  endtask

  task automatic test_sat_thresh();
    int e;
    fill_step(MAX);
    drive_frame(3, 0, 0, 0, -1, NP, 4);
    checks++;
    if (cap_data.size() != NP || cap_data[4 * IW + 4] !== MAX) begin
      errors++; $display("FAIL sat_point got %0d want %0d",
                         (cap_data.size() == NP) ? cap_data[4 * IW + 4] : -1, MAX);
    end
    for (int i = 0; i < NP && i < cap_data.size(); i++) begin
      e = ref_pix(i % IW, i / IW, 3, 0, 0);
      checks++;
      if (cap_data[i] !== e || cap_border[i] !== exp_border(i)) begin
        errors++; $display("FAIL sat i=%0d got d=%0d b=%0d want d=%0d b=%0d",
                           i, cap_data[i], cap_border[i], e, exp_border(i));
      end
    end
    fill_step(500);
    drive_frame(1, 1, 1500, 0, -1, NP, 4);
    checks++;
    if (cap_data.size() != NP || cap_data[5 * IW + 5] !== MAX || cap_data[6 * IW + 5] !== 0) begin
      errors++; $display("FAIL thresh_points got %0d,%0d want %0d,0",
                         (cap_data.size() == NP) ? cap_data[5 * IW + 5] : -1,
                         (cap_data.size() == NP) ? cap_data[6 * IW + 5] : -1, MAX);
    end
    for (int i = 0; i < NP && i < cap_data.size(); i++) begin
      e = ref_pix(i % IW, i / IW, 1, 1, 1500);
      checks++;
      if (cap_data[i] !== e || cap_border[i] !== exp_border(i)) begin
        errors++; $display("FAIL thresh i=%0d got d=%0d b=%0d want d=%0d b=%0d",
                           i, cap_data[i], cap_border[i], e, exp_border(i));
      end
    end
  endtask

  task automatic test_mode_latch();
    int e;
    fill_step(500);
    // iMode drops to PASS right after iSOF; the frame must stay SOBEL_H.
    drive_frame(1, 0, 0, 0, 0, NP, 4);
    checks++;
    if (cap_data.size() != NP) begin
      errors++; $display("FAIL latch_count got %0d want %0d", cap_data.size(), NP);
    end
    for (int i = 0; i < NP && i < cap_data.size(); i++) begin
      e = ref_pix(i % IW, i / IW, 1, 0, 0);
      checks++;
      if (cap_data[i] !== e) begin
        errors++; $display("FAIL latch_h i=%0d got %0d want %0d", i, cap_data[i], e);
      end
    end
    fill_rand();
    drive_frame(0, 0, 0, 0, 0, NP, 4);
    for (int i = 0; i < NP && i < cap_data.size(); i++) begin
      e = ref_pix(i % IW, i / IW, 0, 0, 0);
      checks++;
      if (cap_data[i] !== e || cap_border[i] !== exp_border(i)) begin
        errors++; $display("FAIL latch_pass i=%0d got %0d want %0d", i, cap_data[i], e);
      end
    end
  endtask

  task automatic test_gapped();
    int e, m;
    fill_rand();
    m = int'($urandom_range(0, 3));
    drive_frame(m, 0, 0, 0, -1, NP, 4);
    for (int i = 0; i < NP; i++) saved[i] = (i < cap_data.size()) ? cap_data[i] : -1;
    drive_frame(m, 0, 0, 2, -1, NP, 4);
    checks++;
    if (cap_data.size() != NP) begin
      errors++; $display("FAIL gap_count got %0d want %0d", cap_data.size(), NP);
    end
    for (int i = 0; i < NP && i < cap_data.size(); i++) begin
      e = ref_pix(i % IW, i / IW, m, 0, 0);
      checks++;
      if (cap_data[i] !== e || cap_data[i] !== saved[i] || cap_border[i] !== exp_border(i) ||
          cap_cyc[i] !== in_cyc[i] + 2) begin
        errors++;
        $display("FAIL gap m=%0d i=%0d got d=%0d c=%0d want d=%0d b2b=%0d c=%0d",
                 m, i, cap_data[i], cap_cyc[i], e, saved[i], in_cyc[i] + 2);
      end
    end
  endtask

  task automatic test_random();
    int e, m, ten, th;
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      m   = int'($urandom_range(0, 3));
      ten = int'($urandom_range(0, 1));
      th  = int'($urandom_range(0, MAX));
      drive_frame(m, ten, th, 0, -1, NP, 4);
      checks++;
      if (cap_data.size() != NP) begin
        errors++; $display("FAIL rand_count f=%0d got %0d want %0d", f, cap_data.size(), NP);
      end
      for (int i = 0; i < NP && i < cap_data.size(); i++) begin
        e = ref_pix(i % IW, i / IW, m, ten, th);
        checks++;
        if (cap_data[i] !== e || cap_border[i] !== exp_border(i)) begin
          errors++;
          $display("FAIL rand f=%0d m=%0d te=%0d th=%0d i=%0d got d=%0d b=%0d want d=%0d b=%0d",
                   f, m, ten, th, i, cap_data[i], cap_border[i], e, exp_border(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    fill_rand();
    drive_frame(0, 0, 0, 0, -1, 20, 0);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    checks++;
    if (pix.oDVAL !== 1'b0) begin
      errors++; $display("FAIL rst_mid_dval got %0b want 0", pix.oDVAL);
    end
    iRST = 1'b0;
    cap_data.delete();
    repeat (4) @(posedge iCLK);
    #1;
    checks++;
    if (cap_data.size() != 0) begin
      errors++; $display("FAIL rst_flush got %0d outputs want 0", cap_data.size());
    end
    fill_rand();
    drive_frame(0, 0, 0, 0, -1, NP, 4);
    checks++;
    if (cap_data.size() != NP) begin
      errors++; $display("FAIL rst_count got %0d want %0d", cap_data.size(), NP);
    end
    for (int i = 0; i < NP && i < cap_data.size(); i++) begin
      e = ref_pix(i % IW, i / IW, 0, 0, 0);
      checks++;
      if (cap_data[i] !== e || cap_border[i] !== exp_border(i) ||
          cap_cyc[i] !== in_cyc[i] + 2) begin
        errors++;
        $display("FAIL rst_frame i=%0d got d=%0d b=%0d c=%0d want d=%0d b=%0d c=%0d",
                 i, cap_data[i], cap_border[i], cap_cyc[i], e, exp_border(i), in_cyc[i] + 2);
      end
    end
  endtask

  initial begin
    pix.iSOF      = 1'b0;
    pix.iDVAL     = 1'b0;
    pix.iDATA     = '0;
    pix.iMode     = '0;
    pix.iThreshEn = 1'b0;
    pix.iThresh   = '0;
    test_reset();
    test_flat();
    test_step();
    test_sat_thresh();
    test_mode_latch();
    test_gapped();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
